// File: rtl/wiring_step_controller.sv
// wiring_step_controller: turns the free-running wiring netlist into a
// request/response step engine. A request vector is latched, logic_reset is
// pulsed for one cycle, the vector is pulsed into the netlist for one cycle,
// then the controller waits for wiring_running to stay low for SETTLE_CYCLES
// consecutive cycles (or for the MAX_CYCLES budget to run out) and returns
// the sampled outputs.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. The request side is ready only in IDLE. The response side
// holds rsp_valid and its data stable until rsp_ready is seen.
module wiring_step_controller #(
    parameter int INPUT_WIDTH   = 2,
    parameter int OUTPUT_WIDTH  = 1,
    parameter int SETTLE_CYCLES = 2,
    parameter int MAX_CYCLES    = 1024,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [INPUT_WIDTH-1:0]  req_in,
    output logic [INPUT_WIDTH-1:0]  wiring_in,
    output logic                    wiring_logic_reset,
    input  logic                    wiring_running,
    input  logic [OUTPUT_WIDTH-1:0] wiring_out,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [OUTPUT_WIDTH-1:0] rsp_out,
    output logic [CNT_WIDTH-1:0]    rsp_cycles,
    output logic                    rsp_timeout,
    output logic                    busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FIRE  = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    localparam logic [CNT_WIDTH-1:0] SETTLE_C = CNT_WIDTH'(SETTLE_CYCLES);
    localparam logic [CNT_WIDTH-1:0] MAX_C    = CNT_WIDTH'(MAX_CYCLES);

    // state_q is left visible at this level so checkers can bind to it
    state_t                  state_q, state_d;
    logic [INPUT_WIDTH-1:0]  vec_q, vec_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]    quiet_q, quiet_d;
    logic [OUTPUT_WIDTH-1:0] rsp_out_q, rsp_out_d;
    logic [CNT_WIDTH-1:0]    rsp_cycles_q, rsp_cycles_d;
    logic                    rsp_timeout_q, rsp_timeout_d;

    // State and holding registers; reset returns everything to idle/zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            vec_q         <= '0;
            cnt_q         <= '0;
            quiet_q       <= '0;
            rsp_out_q     <= '0;
            rsp_cycles_q  <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            vec_q         <= vec_d;
            cnt_q         <= cnt_d;
            quiet_q       <= quiet_d;
            rsp_out_q     <= rsp_out_d;
            rsp_cycles_q  <= rsp_cycles_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    // Next-state logic: sequence CLEAR -> FIRE -> WAIT, settle beats timeout
    always_comb begin
        state_d       = state_q;
        vec_d         = vec_q;
        cnt_d         = cnt_q;
        quiet_d       = quiet_q;
        rsp_out_d     = rsp_out_q;
        rsp_cycles_d  = rsp_cycles_q;
        rsp_timeout_d = rsp_timeout_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    vec_d   = req_in;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                cnt_d   = '0;
                quiet_d = '0;
                state_d = S_FIRE;
            end
            S_FIRE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // The counters stop advancing once we leave WAIT, so they
                // never exceed MAX_CYCLES / SETTLE_CYCLES and cannot wrap.
                cnt_d   = cnt_q + CNT_WIDTH'(1);
                quiet_d = wiring_running ? '0 : quiet_q + CNT_WIDTH'(1);
                if (quiet_d == SETTLE_C) begin
                    rsp_out_d     = wiring_out;
                    rsp_cycles_d  = cnt_d;
                    rsp_timeout_d = 1'b0;
                    state_d       = S_RESP;
                end else if (cnt_d == MAX_C) begin
                    rsp_out_d     = wiring_out;
                    rsp_cycles_d  = MAX_C;
                    rsp_timeout_d = 1'b1;
                    state_d       = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the state register and holding registers
    assign req_ready          = (state_q == S_IDLE);
    assign busy               = (state_q != S_IDLE);
    assign wiring_logic_reset = (state_q == S_CLEAR);
    assign wiring_in          = (state_q == S_FIRE) ? vec_q : '0;
    assign rsp_valid          = (state_q == S_RESP);
    assign rsp_out            = rsp_out_q;
    assign rsp_cycles         = rsp_cycles_q;
    assign rsp_timeout        = rsp_timeout_q;

endmodule

// File: tb/tb_wiring_step_controller.sv
// Bench for wiring_step_controller: directed steps plus randomized
// transactions, each checked against a window-based settle model.
module tb_wiring_step_controller;

    localparam int IW = 2;
    localparam int OW = 1;
    localparam int SC = 2;
    localparam int MC = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [IW-1:0] req_in;
    logic [IW-1:0] wiring_in;
    logic          wiring_logic_reset;
    logic          wiring_running;
    logic [OW-1:0] wiring_out;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [OW-1:0] rsp_out;
    logic [CW-1:0] rsp_cycles;
    logic          rsp_timeout;
    logic          busy;

    int n_assert = 0;
    int n_fail   = 0;

    // Netlist running pattern: WAIT cycle k (1-based) uses run_bits[k-1]
    // while k <= pat_len, otherwise run_tail.
    logic [31:0] run_bits;
    int          pat_len;
    logic        run_tail;

    wiring_step_controller #(
        .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .SETTLE_CYCLES(SC),
        .MAX_CYCLES(MC), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_in(req_in),
        .wiring_in(wiring_in), .wiring_logic_reset(wiring_logic_reset),
        .wiring_running(wiring_running), .wiring_out(wiring_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_out(rsp_out),
        .rsp_cycles(rsp_cycles), .rsp_timeout(rsp_timeout), .busy(busy)
    );

    // clock
    always #5 clk = ~clk;

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic run_at(input int k);
        return (k <= pat_len) ? run_bits[k-1] : run_tail;
    endfunction

    // Reference: the first WAIT cycle k that closes a window of SC
    // consecutive quiet cycles settles; otherwise the budget MC times out.
    function automatic void model(output int cyc, output logic to);
        cyc = MC;
        to  = 1'b1;
        for (int k = SC; k <= MC; k++) begin
            bit quiet = 1'b1;
            for (int j = k - SC + 1; j <= k; j++)
                if (run_at(j)) quiet = 1'b0;
            if (quiet) begin
                cyc = k;
                to  = 1'b0;
                return;
            end
        end
    endfunction

    task automatic set_pat(input int len, input logic [31:0] bits, input logic tail);
        pat_len  = len;
        run_bits = bits;
        run_tail = tail;
    endtask

    // One full transaction from IDLE, with `hold` cycles of response backpressure
    task automatic do_txn(input logic [IW-1:0] vec, input logic [OW-1:0] outv, input int hold);
        int   exp_c;
        logic exp_to;
        model(exp_c, exp_to);
        chk("idle_ready", req_ready, 1);
        chk("idle_lr", wiring_logic_reset, 0);
        chk("idle_busy", busy, 0);
        req_valid = 1'b1;
        req_in = vec;
        wiring_running = 1'b1;
        wiring_out = ~outv;
        step();
        req_valid = 1'b0;
        req_in = IW'($urandom);
        chk("clear_lr", wiring_logic_reset, 1);
        chk("clear_in", wiring_in, 0);
        chk("clear_ready", req_ready, 0);
        chk("clear_busy", busy, 1);
        step();
        chk("fire_lr", wiring_logic_reset, 0);
        chk("fire_in", wiring_in, vec);
        for (int k = 1; k <= exp_c; k++) begin
            step();
            chk("wait_valid", rsp_valid, 0);
            chk("wait_in", wiring_in, 0);
            chk("wait_lr", wiring_logic_reset, 0);
            wiring_running = run_at(k);
            wiring_out = (k == exp_c) ? outv : ~outv;
        end
        step();
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_out", rsp_out, outv);
        chk("rsp_cycles", rsp_cycles, exp_c);
        chk("rsp_timeout", rsp_timeout, exp_to);
        chk("rsp_ready_low", req_ready, 0);
        wiring_out = ~outv;
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            req_in = IW'($urandom);
            wiring_running = 1'($urandom);
            step();
            chk("hold_valid", rsp_valid, 1);
            chk("hold_out", rsp_out, outv);
            chk("hold_cycles", rsp_cycles, exp_c);
            chk("hold_timeout", rsp_timeout, exp_to);
            chk("hold_req_ready", req_ready, 0);
            chk("hold_in", wiring_in, 0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("done_valid", rsp_valid, 0);
        chk("done_busy", busy, 0);
        chk("done_ready", req_ready, 1);
        chk("done_cycles_held", rsp_cycles, exp_c);
        chk("done_out_held", rsp_out, outv);
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0;
        req_in = '0;
        wiring_running = 1'b0;
        wiring_out = '0;
        rsp_ready = 1'b0;
        set_pat(0, 32'h0, 1'b0);
        #2;
        chk("rst_valid", rsp_valid, 0);
        chk("rst_in", wiring_in, 0);
        chk("rst_lr", wiring_logic_reset, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", req_ready, 1);
        req_valid = 1'b1;
        req_in = 2'b11;
        step();
        step();
        chk("rst_no_accept", busy, 0);
        chk("rst_cycles", rsp_cycles, 0);
        req_valid = 1'b0;
        reset = 1'b0;
        step();

        // basic step: running for WAIT cycles 1-3, then quiet
        set_pat(3, 32'b111, 1'b0);
        do_txn(2'b11, 1'b1, 0);
        // immediate settle
        set_pat(0, 32'h0, 1'b0);
        do_txn(2'b01, 1'b0, 0);
        // glitch restart: 1,0,1,0,0
        set_pat(3, 32'b101, 1'b0);
        do_txn(2'b10, 1'b1, 1);
        // settle on the same cycle the budget runs out
        set_pat(6, 32'b111111, 1'b0);
        do_txn(2'b01, 1'b1, 0);
        // timeout, then backpressure with competing requests
        set_pat(0, 32'h0, 1'b1);
        do_txn(2'b11, 1'b0, 10);

        // async reset during CLEAR
        req_valid = 1'b1;
        req_in = 2'b10;
        step();
        req_valid = 1'b0;
        chk("abort1_lr_before", wiring_logic_reset, 1);
        #2 reset = 1'b1;
        #1;
        chk("abort1_lr", wiring_logic_reset, 0);
        chk("abort1_busy", busy, 0);
        chk("abort1_ready", req_ready, 1);
        chk("abort1_timeout", rsp_timeout, 0);
        step();
        reset = 1'b0;
        step();
        chk("abort1_idle_valid", rsp_valid, 0);

        // complete one, then async reset mid-WAIT of the next
        set_pat(2, 32'b11, 1'b0);
        do_txn(2'b01, 1'b1, 0);
        wiring_running = 1'b1;
        req_valid = 1'b1;
        req_in = 2'b11;
        step();
        req_valid = 1'b0;
        step();
        chk("abort2_fire_in", wiring_in, 2'b11);
        step();
        step();
        chk("abort2_wait_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("abort2_busy", busy, 0);
        chk("abort2_valid", rsp_valid, 0);
        chk("abort2_in", wiring_in, 0);
        chk("abort2_ready", req_ready, 1);
        chk("abort2_cycles", rsp_cycles, 0);
        chk("abort2_out", rsp_out, 0);
        step();
        reset = 1'b0;
        step();
        chk("abort2_no_rsp", rsp_valid, 0);
        set_pat(1, 32'b1, 1'b0);
        do_txn(2'b10, 1'b0, 2);

        // randomized transactions
        for (int t = 0; t < 20; t++) begin
            set_pat($urandom_range(0, 10), $urandom, 1'($urandom_range(0, 1)));
            do_txn(IW'($urandom), OW'($urandom), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
